// File: rtl/finger_pkg.sv
// Shared types and constants for the finger-sum accumulator.
package finger_pkg;

  typedef enum logic [1:0] {
    WAIT_NEUTRAL = 2'd0,
    WAIT_SIGN    = 2'd1,
    OUTPUT       = 2'd2
  } state_t;

  localparam logic [3:0] NEUTRAL_CODE   = 4'd0;
  localparam logic [3:0] MAX_VALID_CODE = 4'd10;

  // Codes above MAX_VALID_CODE come from a misbehaving converter
  function automatic logic is_legal(input logic [3:0] code);
    return code <= MAX_VALID_CODE;
  endfunction

endpackage

// File: rtl/finger_debounce.sv
// Run-length debouncer: pulses once when a legal sample has been held
// for STABLE_CYCLES consecutive cycles.
module finger_debounce #(
  parameter int W             = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         restart,
  input  logic [W-1:0] sample,
  input  logic         legal,
  output logic         stable,
  output logic [W-1:0] value
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

  logic [W-1:0]  prev_q;
  logic [RW-1:0] run_q;
  logic [RW-1:0] run_d;

  // Run length including the current sample; illegal samples pin it at zero
  always_comb begin
    run_d = '0;
    if (!legal) begin
      run_d = '0;
    end else if (sample == prev_q) begin
      run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RW'(1);
    end else begin
      run_d = RW'(1);
    end
  end

  // Remember last sample and run length; restart forgets all history
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      prev_q <= '0;
      run_q  <= '0;
    end else begin
      prev_q <= sample;
      run_q  <= run_d;
    end
  end

  assign stable = (run_d == RUN_MAX) && (run_q != RUN_MAX);
  assign value  = sample;

endmodule

// File: rtl/finger_sum_accumulator.sv
// Accumulates debounced hand-sign counts into a saturating sum and
// delivers it over a valid/ready handshake.
module finger_sum_accumulator
  import finger_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SUM_W         = 8,
  parameter int MAX_TERMS     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       n,
  input  logic             done,
  input  logic             clear,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [SUM_W-1:0] sum,
  output logic [3:0]       term_count,
  output logic             overflow,
  output logic             bad_code
);

  localparam int EW = SUM_W + 1;
  localparam logic [SUM_W:0] SUM_MAX_EXT = {1'b0, {SUM_W{1'b1}}};
  localparam logic [3:0]     TERM_LIMIT  = 4'(MAX_TERMS);

  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [3:0]       term_q, term_d, term_inc;
  logic             ovf_q, ovf_d;
  logic             bad_q, bad_d;
  logic             valid_q, valid_d;
  logic             handshake;
  logic             commit;
  logic             illegal;
  logic             deb_stable;
  logic [3:0]       deb_value;
  logic [SUM_W:0]   n_ext;
  logic [SUM_W:0]   add_ext;
  logic             add_over;

  assign illegal = !is_legal(n);

  finger_debounce #(
    .W             (4),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .restart (clear | handshake),
    .sample  (n),
    .legal   (!illegal),
    .stable  (deb_stable),
    .value   (deb_value)
  );

  // Saturating add of the widened count onto the running sum
  always_comb begin
    n_ext    = EW'(n);
    add_ext  = {1'b0, sum_q} + n_ext;
    add_over = add_ext > SUM_MAX_EXT;
    term_inc = term_q + 4'd1;
    commit   = (state_q == WAIT_SIGN) && deb_stable &&
               (deb_value != NEUTRAL_CODE) && is_legal(deb_value);
  end

  // Next-state and datapath update; a commit lands before any delivery
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    term_d    = term_q;
    ovf_d     = ovf_q;
    bad_d     = bad_q | illegal;
    valid_d   = valid_q;
    handshake = 1'b0;
    case (state_q)
      WAIT_NEUTRAL: begin
        if (done) begin
          state_d = OUTPUT;
          valid_d = 1'b1;
        end else if (deb_stable && deb_value == NEUTRAL_CODE) begin
          state_d = WAIT_SIGN;
        end
      end
      WAIT_SIGN: begin
        if (commit) begin
          sum_d   = add_over ? SUM_MAX_EXT[SUM_W-1:0] : add_ext[SUM_W-1:0];
          ovf_d   = ovf_q | add_over;
          term_d  = term_inc;
          state_d = WAIT_NEUTRAL;
        end
        if (done || (commit && term_inc == TERM_LIMIT)) begin
          state_d = OUTPUT;
          valid_d = 1'b1;
        end
      end
      OUTPUT: begin
        if (valid_q && sum_ready) begin
          sum_d     = '0;
          term_d    = '0;
          ovf_d     = 1'b0;
          bad_d     = 1'b0;
          valid_d   = 1'b0;
          state_d   = WAIT_NEUTRAL;
          handshake = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_NEUTRAL;
      end
    endcase
  end

  // State register; clear behaves like reset
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= WAIT_NEUTRAL;
      sum_q   <= '0;
      term_q  <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      term_q  <= term_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
      valid_q <= valid_d;
    end
  end

  assign sum_valid  = valid_q;
  assign sum        = sum_q;
  assign term_count = term_q;
  assign overflow   = ovf_q;
  assign bad_code   = bad_q;

endmodule

// File: tb/tb_finger_sum_accumulator.sv
// Scenario bench for finger_sum_accumulator; three parameterisations share stimulus.
module tb_finger_sum_accumulator;

  typedef struct packed {
    logic [7:0] sum;
    logic [3:0] term;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, done, clear, sum_ready;
  logic [3:0] n;

  logic       valid_a, ovf_a, bad_a;
  logic [7:0] sum_a;
  logic [3:0] term_a;
  logic       valid_b, ovf_b, bad_b;
  logic [3:0] sum_b;
  logic [3:0] term_b;
  logic       valid_c, ovf_c, bad_c;
  logic [7:0] sum_c;
  logic [3:0] term_c;

  logic       obs_valid, obs_ovf, obs_bad;
  logic [7:0] obs_sum;
  logic [3:0] obs_term;
  int         sel = 0;

  int   n_compared = 0;
  int   n_mismatched = 0;
  exp_t exp_q[$];
  exp_t e;
  int   waited;
  bit   ok;

  always #5 clk = ~clk;

  finger_sum_accumulator #(.STABLE_CYCLES(4), .SUM_W(8), .MAX_TERMS(8)) dut_a (
    .clk(clk), .reset(reset), .n(n), .done(done), .clear(clear),
    .sum_valid(valid_a), .sum_ready(sum_ready), .sum(sum_a),
    .term_count(term_a), .overflow(ovf_a), .bad_code(bad_a));

  finger_sum_accumulator #(.STABLE_CYCLES(4), .SUM_W(4), .MAX_TERMS(8)) dut_b (
    .clk(clk), .reset(reset), .n(n), .done(done), .clear(clear),
    .sum_valid(valid_b), .sum_ready(sum_ready), .sum(sum_b),
    .term_count(term_b), .overflow(ovf_b), .bad_code(bad_b));

  finger_sum_accumulator #(.STABLE_CYCLES(4), .SUM_W(8), .MAX_TERMS(2)) dut_c (
    .clk(clk), .reset(reset), .n(n), .done(done), .clear(clear),
    .sum_valid(valid_c), .sum_ready(sum_ready), .sum(sum_c),
    .term_count(term_c), .overflow(ovf_c), .bad_code(bad_c));

  // Route the instance under test to a common set of observation signals
  always_comb begin
    obs_valid = valid_a; obs_sum = sum_a; obs_term = term_a; obs_ovf = ovf_a; obs_bad = bad_a;
    case (sel)
      1: begin obs_valid = valid_b; obs_sum = {4'd0, sum_b}; obs_term = term_b; obs_ovf = ovf_b; obs_bad = bad_b; end
      2: begin obs_valid = valid_c; obs_sum = sum_c; obs_term = term_c; obs_ovf = ovf_c; obs_bad = bad_c; end
      default: ;
    endcase
  end

  task automatic applyStimulus(input logic [3:0] val, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      n = val;
      @(negedge clk);
    end
  endtask

  task automatic pulse_clear();
    n = 4'd0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic do_reset();
    n = 4'd0; done = 1'b0; clear = 1'b0; sum_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(output int w, output bit found);
    w = 0; found = 1'b0;
    while (w < 20) begin
      if (obs_valid === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
      w++;
    end
  endtask

  task automatic test_reset();
    sel = 0;
    n = 4'd0; done = 1'b0; clear = 1'b0; sum_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_compared++; if (obs_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %0d expected 0", obs_valid); end
    n_compared++; if (obs_sum !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_sum: got %0d expected 0", obs_sum); end
    n_compared++; if (obs_term !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_term: got %0d expected 0", obs_term); end
    n_compared++; if ({obs_ovf, obs_bad} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_flags: got %b expected 00", {obs_ovf, obs_bad}); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_commit();
    sel = 0;
    applyStimulus(4'd0, 4);
    applyStimulus(4'd3, 4);
    n_compared++; if (obs_sum !== 8'd3) begin n_mismatched++; $display("[TB] FAIL commit_sum: got %0d expected 3", obs_sum); end
    n_compared++; if (obs_term !== 4'd1) begin n_mismatched++; $display("[TB] FAIL commit_term: got %0d expected 1", obs_term); end
    n = 4'd0; sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    n_compared++; if (obs_sum !== 8'd3 || obs_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stray_ready: got sum %0d valid %0d expected sum 3 valid 0", obs_sum, obs_valid); end
    exp_q.push_back('{sum: 8'd3, term: 4'd1, ovf: 1'b0});
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_valid(waited, ok);
    n_compared++; if (!ok || waited != 0) begin n_mismatched++; $display("[TB] FAIL done_latency: got %0d cycles expected 0", waited); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    n_compared++; if (obs_sum !== e.sum || obs_term !== e.term || obs_ovf !== e.ovf) begin n_mismatched++; $display("[TB] FAIL done_result: got %0d/%0d/%0d expected %0d/%0d/%0d", obs_sum, obs_term, obs_ovf, e.sum, e.term, e.ovf); end
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    n_compared++; if (obs_valid !== 1'b0 || obs_sum !== 8'd0 || obs_term !== 4'd0) begin n_mismatched++; $display("[TB] FAIL handshake_clear: got valid %0d sum %0d term %0d expected 0 0 0", obs_valid, obs_sum, obs_term); end
  endtask

  task automatic test_mid_gesture();
    sel = 0;
    applyStimulus(4'd0, 4);
    applyStimulus(4'd5, 3);
    n_compared++; if (obs_term !== 4'd0) begin n_mismatched++; $display("[TB] FAIL short_run_term: got %0d expected 0", obs_term); end
    applyStimulus(4'd6, 4);
    n_compared++; if (obs_sum !== 8'd6) begin n_mismatched++; $display("[TB] FAIL restart_sum: got %0d expected 6", obs_sum); end
    applyStimulus(4'd9, 8);
    n_compared++; if (obs_sum !== 8'd6 || obs_term !== 4'd1) begin n_mismatched++; $display("[TB] FAIL no_neutral: got sum %0d term %0d expected 6 1", obs_sum, obs_term); end
    pulse_clear();
  endtask

  task automatic test_done_empty();
    sel = 0;
    exp_q.push_back('{sum: 8'd0, term: 4'd0, ovf: 1'b0});
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_valid(waited, ok);
    n_compared++; if (!ok) begin n_mismatched++; $display("[TB] FAIL empty_valid: got timeout expected valid"); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    n_compared++; if (obs_sum !== e.sum || obs_term !== e.term) begin n_mismatched++; $display("[TB] FAIL empty_result: got %0d/%0d expected %0d/%0d", obs_sum, obs_term, e.sum, e.term); end
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
  endtask

  task automatic test_illegal();
    sel = 0;
    applyStimulus(4'd0, 4);
    applyStimulus(4'd12, 6);
    n_compared++; if (obs_bad !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bad_code: got %0d expected 1", obs_bad); end
    n_compared++; if (obs_term !== 4'd0) begin n_mismatched++; $display("[TB] FAIL illegal_commit: got %0d expected 0", obs_term); end
    pulse_clear();
    n_compared++; if ({obs_valid, obs_ovf, obs_bad} !== 3'b000 || obs_sum !== 8'd0) begin n_mismatched++; $display("[TB] FAIL clear_outputs: got flags %b sum %0d expected 000 0", {obs_valid, obs_ovf, obs_bad}, obs_sum); end
    applyStimulus(4'd5, 4);
    n_compared++; if (obs_term !== 4'd0) begin n_mismatched++; $display("[TB] FAIL clear_state: got term %0d expected 0", obs_term); end
    pulse_clear();
  endtask

  task automatic test_done_on_commit();
    sel = 0;
    applyStimulus(4'd0, 4);
    applyStimulus(4'd7, 3);
    exp_q.push_back('{sum: 8'd7, term: 4'd1, ovf: 1'b0});
    n = 4'd7; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_valid(waited, ok);
    n_compared++; if (!ok || waited != 0) begin n_mismatched++; $display("[TB] FAIL commit_done_latency: got %0d expected 0", waited); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    n_compared++; if (obs_sum !== e.sum || obs_term !== e.term) begin n_mismatched++; $display("[TB] FAIL commit_done_result: got %0d/%0d expected %0d/%0d", obs_sum, obs_term, e.sum, e.term); end
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
  endtask

  task automatic test_saturate();
    sel = 1;
    do_reset();
    applyStimulus(4'd0, 4);
    applyStimulus(4'd10, 4);
    applyStimulus(4'd0, 4);
    applyStimulus(4'd9, 4);
    n_compared++; if (obs_sum !== 8'd15 || obs_ovf !== 1'b1) begin n_mismatched++; $display("[TB] FAIL saturate: got sum %0d ovf %0d expected 15 1", obs_sum, obs_ovf); end
    exp_q.push_back('{sum: 8'd15, term: 4'd2, ovf: 1'b1});
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_valid(waited, ok);
    n_compared++; if (!ok) begin n_mismatched++; $display("[TB] FAIL sat_valid: got timeout expected valid"); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    n_compared++; if (obs_sum !== e.sum || obs_term !== e.term || obs_ovf !== e.ovf) begin n_mismatched++; $display("[TB] FAIL sat_result: got %0d/%0d/%0d expected %0d/%0d/%0d", obs_sum, obs_term, obs_ovf, e.sum, e.term, e.ovf); end
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 2;
    do_reset();
    applyStimulus(4'd0, 4);
    applyStimulus(4'd2, 4);
    applyStimulus(4'd0, 4);
    exp_q.push_back('{sum: 8'd6, term: 4'd2, ovf: 1'b0});
    applyStimulus(4'd4, 4);
    wait_valid(waited, ok);
    n_compared++; if (!ok || waited != 0) begin n_mismatched++; $display("[TB] FAIL auto_latency: got %0d expected 0", waited); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    n_compared++; if (obs_sum !== e.sum || obs_term !== e.term) begin n_mismatched++; $display("[TB] FAIL auto_result: got %0d/%0d expected %0d/%0d", obs_sum, obs_term, e.sum, e.term); end
    n = 4'd9; done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_compared++; if (obs_valid !== 1'b1 || obs_sum !== 8'd6) begin n_mismatched++; $display("[TB] FAIL hold_%0d: got valid %0d sum %0d expected 1 6", i, obs_valid, obs_sum); end
    end
    done = 1'b0; sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    n_compared++; if (obs_valid !== 1'b0 || obs_term !== 4'd0) begin n_mismatched++; $display("[TB] FAIL auto_release: got valid %0d term %0d expected 0 0", obs_valid, obs_term); end
  endtask

  initial begin
    reset = 1'b1; n = 4'd0; done = 1'b0; clear = 1'b0; sum_ready = 1'b0;
    test_reset();
    test_basic_commit();
    test_mid_gesture();
    test_done_empty();
    test_illegal();
    test_done_on_commit();
    test_saturate();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
